// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, baud divider helper and the
// release-pacing FSM encoding used by the loopback buffer.
package uart_pkg;

  localparam int UART_FRAME_DATA_BITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } gap_state_e;

  function automatic int baud_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO with a registered read port; a write while full
// is accepted only when a pop frees a slot on the same edge.
module sync_fifo_byte
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en_i,
  input  logic [UART_FRAME_DATA_BITS-1:0] wr_dat_i,
  input  logic                            rd_en_i,
  output logic [UART_FRAME_DATA_BITS-1:0] rd_dat_o,
  output logic [ADDR_W:0]                 cnt_o,
  output logic                            full_o,
  output logic                            empty_o
);

  logic [UART_FRAME_DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]                 cnt_q, cnt_d;
  logic [UART_FRAME_DATA_BITS-1:0] rd_dat_q, rd_dat_d;
  logic                            wr_acc, rd_acc;

  assign full_o  = (cnt_q == (ADDR_W + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rd_acc  = rd_en_i && !empty_o;
  assign wr_acc  = wr_en_i && (!full_o || rd_acc);

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_dat_d = rd_acc ? mem[rd_ptr_q] : rd_dat_q;
    cnt_d    = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_dat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat_o = rd_dat_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/uart_loopback_fifo.sv
// Loopback elastic buffer: queues received bytes and releases one per frame
// time to a transmitter that has no busy handshake.
module uart_loopback_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FRAME_BITS = 11
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [UART_FRAME_DATA_BITS-1:0] pi_data,
  input  logic                            pi_flag,
  output logic [UART_FRAME_DATA_BITS-1:0] po_data,
  output logic                            po_flag,
  output logic [ADDR_W:0]                 fifo_cnt,
  output logic                            overflow
);

  localparam int BAUD_CNT_MAX = baud_cnt(CLK_FREQ, UART_BPS);
  localparam int GAP_CYC      = BAUD_CNT_MAX * FRAME_BITS;
  localparam int GAP_W        = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  gap_state_e       state_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             po_flag_q;
  logic             overflow_q;
  logic             full, empty, pop;

  assign pop = (state_q == IDLE) && !empty;

  sync_fifo_byte #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (pi_flag),
    .wr_dat_i (pi_data),
    .rd_en_i  (pop),
    .rd_dat_o (po_data),
    .cnt_o    (fifo_cnt),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Leaving WAIT at GAP_CYC-2 lets the next pop land exactly GAP_CYC after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      po_flag_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (pi_flag && full && !pop) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          po_flag_q <= pop;
          if (pop) begin
            state_q   <= WAIT;
            gap_cnt_q <= '0;
          end
        end
        WAIT: begin
          po_flag_q <= 1'b0;
          gap_cnt_q <= gap_cnt_q + 1'b1;
          if (gap_cnt_q == GAP_W'(GAP_CYC - 2)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign po_flag  = po_flag_q;
  assign overflow = overflow_q;

endmodule

// File: doc/uart_loopback_fifo.md
Name: uart_loopback_fifo

Overview:
- Elastic byte buffer between the UART receiver output (po_data/po_flag) and the UART transmitter input (pi_data/pi_flag) in the Rs232 loopback path.
- The transmitter has no ready/busy handshake, so back-to-back received bytes can arrive while it is still sending.
- This block queues received bytes in a synchronous FIFO and releases them one at a time.
- Releases are spaced by one full frame time, so no byte is lost or truncated at tx.

Parameters:
- DEPTH, 16: FIFO depth in bytes; power of two, minimum 2.
- ADDR_W, 4: log2(DEPTH).
- UART_BPS, 9600: line baud rate.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- FRAME_BITS, 11: bit times reserved per emitted byte (start + 8 data + stop + 1 guard).
- Derived localparam BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division).
- Derived localparam GAP_CYC = BAUD_CNT_MAX*FRAME_BITS. Default 5208*11 = 57288.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- pi_data  input  8  byte from receiver; valid when pi_flag=1.
- pi_flag  input  1  one-cycle write strobe from receiver.
- po_data  output  8  byte to transmitter; held stable between emissions.
- po_flag  output  1  one-cycle strobe to transmitter.
- fifo_cnt  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a byte was dropped because the FIFO was full.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: po_data=8'h00, po_flag=0, fifo_cnt=0, overflow=0, state=IDLE, gap counter=0, read/write pointers=0.
- Reset mid-operation discards all queued bytes and aborts any gap wait.
- Write: pi_flag=1 on a rising edge with fifo_cnt<DEPTH stores pi_data at wr_ptr. wr_ptr increments mod DEPTH.
- Write when full, with no pop in the same cycle: the byte is dropped, overflow goes to 1 and stays there until reset, fifo_cnt is unchanged.
- Pop and write in the same cycle when full: the write is accepted and fifo_cnt stays at DEPTH.
- There is no bypass path. A byte written into an empty FIFO becomes poppable on the next edge.
- fifo_cnt: +1 on write only, -1 on pop only, unchanged on both or neither. Pointers wrap naturally at DEPTH.
- FSM states:
  - IDLE: if fifo_cnt!=0, pop. po_data<=mem[rd_ptr], po_flag<=1, rd_ptr++, go to WAIT with gap_cnt<=0.
  - WAIT: po_flag<=0 and gap_cnt++. When gap_cnt==GAP_CYC-2, go to IDLE.
- The FIFO read is a registered read, so po_data and po_flag change on the same edge.
- Latency: pi_flag high in cycle k into an empty, IDLE block gives po_flag high in cycle k+2.
- Spacing: consecutive po_flag pulses are exactly GAP_CYC cycles apart while the FIFO stays non-empty. If it runs empty, the next pulse comes at max(GAP_CYC, arrival+2).
- po_flag is never high for two consecutive cycles.
- po_data changes only on the edge that raises po_flag.
- No pop happens in WAIT, even if the FIFO is full.

Decomposition:
- Shared package uart_pkg:
  - UART_FRAME_DATA_BITS=8.
  - A function baud_cnt(clk_freq, bps) returning clk_freq/bps, reused by Rs232_rx and Rs232_tx.
  - The FSM state encoding (IDLE=1'b0, WAIT=1'b1).
- One sub-module, sync_fifo_byte. It holds the memory, pointers, count, full/empty and the registered read port, parameterised by DEPTH/ADDR_W.
- The top holds the FSM, gap counter, po_flag and the overflow flag.

Test Plan (sim parameters CLK_FREQ=1000, UART_BPS=100, FRAME_BITS=11, so GAP_CYC=110; DEPTH=4):
1. Single byte 8'hA5 on pi_flag at cycle 10 -> po_flag only at cycle 12 with po_data=8'hA5; fifo_cnt goes 0->1->0.
2. Burst of 3 bytes 8'h01, 8'h02, 8'h03 on consecutive cycles 10-12 -> po_flag at 12, 122, 232 carrying 01, 02, 03 in order; fifo_cnt peaks at 2.
3. Six bytes 8'h10..8'h15 on consecutive cycles -> bytes 10..14 emitted (one popped early, frees one slot), 8'h15 dropped, overflow=1 sticky, fifo_cnt never exceeds 4.
4. Write on the exact cycle of a pop while full -> byte accepted, fifo_cnt stays 4, no overflow; emission order preserved across pointer wrap (feed 10 bytes spaced 50 cycles apart).
5. Assert rst_n=0 for 1 cycle mid-WAIT with 3 bytes queued -> outputs immediately at reset values; after release no po_flag until a new pi_flag; next byte emitted 2 cycles after its arrival.
6. Byte arrives 40 cycles after a pulse at cycle 12 -> next po_flag at cycle 122, not earlier.
